sprite_palette_renderer: RTL and testbench
==========================================

Name: sprite_palette_renderer

Overview:
- Pipelined, parametrised sprite pixel renderer between the VGA scan counter and the colour mux.
- Each pixel strobe: tests DrawX/DrawY against a sprite box, computes the packed sprite-ROM word address and pixel slot, waits for the ROM read latency, then extracts the palette index.
- Maps the index through a writable palette RAM to 4:4:4 RGB. Drives a per-pixel opaque hit flag so the colour mux can layer the sprite over the background.
- Adds to the previous per-sprite palette modules: multi-frame animation, horizontal flip, transparency, a runtime-loadable palette, and frame-synchronous sprite state.

Parameters:
SPR_W, 20, sprite width in pixels
SPR_H, 20, sprite height in pixels
BPP, 4, bits per pixel (palette index width); palette depth = 2**BPP
DATA_W, 32, ROM word width; PPW = DATA_W/BPP pixels per word, must be an integer
FRAMES, 4, animation frames stored back to back in ROM
ROM_LAT, 1, ROM read latency in Clk cycles (1..3)
ADDR_W, 10, rom_addr width; must hold FRAMES*SPR_W*SPR_H/PPW - 1
TRANSP_IDX, 0, palette index treated as transparent

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous, active-low reset
pix_en  in  1  pixel strobe; one pixel evaluated per asserted cycle
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
vsync  in  1  frame sync from the VGA controller
SprX  in  10  sprite top-left X, shadowed at frame start
SprY  in  10  sprite top-left Y, shadowed at frame start
flip  in  1  1 = face left (horizontally mirrored), shadowed at frame start
frame_sel  in  clog2(FRAMES)  animation frame, shadowed at frame start
rom_addr  out  ADDR_W  sprite ROM word address
rom_data  in  DATA_W  ROM word, valid ROM_LAT cycles after rom_addr
pal_we  in  1  palette write strobe
pal_idx  in  BPP  palette entry to write
pal_rgb  in  12  {R,G,B} value to write
Red  out  4  pixel red
Green  out  4  pixel green
Blue  out  4  pixel blue
pix_valid  out  1  Red/Green/Blue/hit correspond to a pixel presented LAT cycles earlier
hit  out  1  pixel is inside the sprite box and not transparent

Behaviour:
- Reset (Reset_n = 0 at a Clk edge):
  - All outputs, pipeline registers and shadow registers go to 0.
  - Palette entry i loads greyscale {i', i', i'}, where i' = i scaled to 4 bits.
  - Reset mid-frame discards all in-flight pixels.
- Shadowing:
  - On a vsync rising edge (registered edge detect), SprX, SprY, flip and frame_sel are copied into shadow registers.
  - All geometry uses the shadow values, so there is no mid-frame tearing.
  - frame_sel >= FRAMES clamps to FRAMES-1.
- Stage 0, registered on pix_en:
  - Inside = SX <= DrawX < SX+SPR_W and SY <= DrawY < SY+SPR_H. Compare at 11 bits so SX+SPR_W > 1023 does not wrap.
  - Column c = DrawX-SX, or SPR_W-1-(DrawX-SX) when flip = 1.
  - Linear index L = (DrawY-SY)*SPR_W + c.
  - Frame base B = frame*(SPR_W*SPR_H/PPW).
  - rom_addr = B + L/PPW; slot = L%PPW.
  - Outside the box: rom_addr holds its previous value, inside = 0.
- Stages 1..ROM_LAT: inside, slot and a valid bit are delayed to align with rom_data.
- Index extract: idx = rom_data[slot*BPP +: BPP]. Pixel 0 is in the LSBs.
- Output stage:
  - {Red, Green, Blue} = palette[idx] when inside and idx != TRANSP_IDX, else 0.
  - hit = inside & (idx != TRANSP_IDX).
- Latency: total LAT = ROM_LAT + 2 cycles from pix_en to pix_valid. pix_valid is pix_en delayed by LAT and is never dropped; fully pipelined at 1 pixel/cycle.
- Palette writes:
  - A write on pal_we is visible to lookups from the next cycle.
  - A write colliding with a lookup of the same entry returns the old value (read-first).
  - Writes are accepted regardless of pix_en.
- pix_en = 0 inserts bubbles; the pipeline still advances and pix_valid = 0 in the matching output cycle.

Decomposition:
- Shared package sprite_pkg: rgb444_t (12-bit packed struct), BPP / PPW derivation functions, the default greyscale palette function.
- One natural sub-module, sprite_palette_ram: 2**BPP x 12, synchronous write, read-first, reset-initialised.
- Address/slot arithmetic and the delay line stay in the top module.

Test Plan:
- Reset then pal_we idx 5 = 12'hE12; SX=100, SY=50, frame 0, flip 0; DrawX=103, DrawY=50, rom_data nibble 3 = 5 -> after LAT cycles RGB = E,1,2, hit = 1, rom_addr = 0.
- Same pixel with flip = 1 latched at vsync -> c = 16, rom_addr = 2, slot 0 selected.
- DrawX=120 (SX+SPR_W) -> hit = 0, RGB = 0, pix_valid = 1.
- frame_sel = 2, DrawX=100, DrawY=51 -> rom_addr = 100 + 2 = 102, slot 4.
- Change SprX mid-frame -> output unchanged until the next vsync edge, then shifted.
- Pixel index TRANSP_IDX inside the box -> hit = 0. Reset_n low mid-stream -> pix_valid = 0 next cycle, palette back to greyscale.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and helper functions for the sprite palette renderer slice.
package sprite_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    function automatic int pixels_per_word(input int data_w, input int bpp);
        return data_w / bpp;
    endfunction

    function automatic int pal_depth(input int bpp);
        return 1 << bpp;
    endfunction

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Entry idx scaled onto the full 0..15 range, replicated on all channels
    function automatic rgb444_t grey_rgb(input int idx, input int bpp);
        logic [3:0] lvl;
        lvl = 4'((idx * 15) / ((1 << bpp) - 1));
        return '{r: lvl, g: lvl, b: lvl};
    endfunction

endpackage

// File: rtl/sprite_palette_renderer_if.sv
// Pixel, sprite-state, ROM and palette-write bus between the scan logic and the renderer.
interface sprite_palette_renderer_if
    import sprite_pkg::*;
#(
    parameter int BPP    = 4,
    parameter int DATA_W = 32,
    parameter int FRAMES = 4,
    parameter int ADDR_W = 10
);
    localparam int FS_W = sel_width(FRAMES);

    logic              pix_en;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              vsync;
    logic [9:0]        SprX;
    logic [9:0]        SprY;
    logic              flip;
    logic [FS_W-1:0]   frame_sel;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              pal_we;
    logic [BPP-1:0]    pal_idx;
    logic [11:0]       pal_rgb;
    logic [3:0]        Red;
    logic [3:0]        Green;
    logic [3:0]        Blue;
    logic              pix_valid;
    logic              hit;

    modport master (
        output pix_en, DrawX, DrawY, vsync, SprX, SprY, flip, frame_sel,
        output rom_data, pal_we, pal_idx, pal_rgb,
        input  rom_addr, Red, Green, Blue, pix_valid, hit
    );

    modport slave (
        input  pix_en, DrawX, DrawY, vsync, SprX, SprY, flip, frame_sel,
        input  rom_data, pal_we, pal_idx, pal_rgb,
        output rom_addr, Red, Green, Blue, pix_valid, hit
    );

endinterface

// File: rtl/sprite_palette_ram.sv
// Writable colour palette: synchronous write, registered read-first lookup,
// greyscale contents restored on reset.
module sprite_palette_ram
    import sprite_pkg::*;
#(
    parameter int BPP = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  logic [BPP-1:0] wr_idx,
    input  rgb444_t        wr_rgb,
    input  logic [BPP-1:0] rd_idx,
    output rgb444_t        rd_rgb
);
    localparam int DEPTH = pal_depth(BPP);

    rgb444_t mem [0:DEPTH-1];
    rgb444_t rd_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= grey_rgb(i, BPP);
            end
            rd_reg <= '0;
        end else begin
            if (we) begin
                mem[wr_idx] <= wr_rgb;
            end
            // Same-edge write lands after this read, so a collision sees the old entry
            rd_reg <= mem[rd_idx];
        end
    end

    assign rd_rgb = rd_reg;

endmodule

// File: rtl/sprite_palette_renderer.sv
// Pipelined sprite renderer: box test and ROM addressing, ROM-latency delay line,
// palette index extraction, palette lookup and registered RGB/hit output.
module sprite_palette_renderer
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 20,
    parameter int SPR_H      = 20,
    parameter int BPP        = 4,
    parameter int DATA_W     = 32,
    parameter int FRAMES     = 4,
    parameter int ROM_LAT    = 1,
    parameter int ADDR_W     = 10,
    parameter int TRANSP_IDX = 0
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    sprite_palette_renderer_if.slave bus
);
    localparam int PPW         = pixels_per_word(DATA_W, BPP);
    localparam int SLOT_W      = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int FS_W        = sel_width(FRAMES);
    localparam int FRAME_WORDS = SPR_W * SPR_H / PPW;

    // Frame-synchronous sprite state
    logic              vsync_reg;
    logic [9:0]        sx_reg;
    logic [9:0]        sy_reg;
    logic              flip_reg;
    logic [FS_W-1:0]   frame_reg;
    logic [FS_W-1:0]   frame_next;

    assign frame_next = (32'(bus.frame_sel) >= FRAMES) ? FS_W'(FRAMES - 1) : bus.frame_sel;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            vsync_reg <= 1'b0;
            sx_reg    <= '0;
            sy_reg    <= '0;
            flip_reg  <= 1'b0;
            frame_reg <= '0;
        end else begin
            vsync_reg <= bus.vsync;
            if (bus.vsync && !vsync_reg) begin
                sx_reg    <= bus.SprX;
                sy_reg    <= bus.SprY;
                flip_reg  <= bus.flip;
                frame_reg <= frame_next;
            end
        end
    end

    // Stage 0 arithmetic; 11-bit compares keep boxes near the right edge from wrapping
    logic [10:0]       x_ext, y_ext, sx_ext, sy_ext;
    logic [9:0]        dx, dy, col;
    logic [31:0]       lin;
    logic              inside_next;
    logic [ADDR_W-1:0] addr_next;
    logic [SLOT_W-1:0] slot_next;

    always_comb begin
        x_ext       = {1'b0, bus.DrawX};
        y_ext       = {1'b0, bus.DrawY};
        sx_ext      = {1'b0, sx_reg};
        sy_ext      = {1'b0, sy_reg};
        inside_next = (x_ext >= sx_ext) && (x_ext < sx_ext + 11'(SPR_W)) &&
                      (y_ext >= sy_ext) && (y_ext < sy_ext + 11'(SPR_H));
        dx          = bus.DrawX - sx_reg;
        dy          = bus.DrawY - sy_reg;
        col         = flip_reg ? (10'(SPR_W - 1) - dx) : dx;
        lin         = 32'(dy) * 32'(SPR_W) + 32'(col);
        addr_next   = ADDR_W'(32'(frame_reg) * 32'(FRAME_WORDS) + lin / 32'(PPW));
        slot_next   = SLOT_W'(lin % 32'(PPW));
    end

    // Entry 0 is stage 0; entry ROM_LAT lines up with rom_data
    logic [ROM_LAT:0]  dly_valid_reg;
    logic [ROM_LAT:0]  dly_inside_reg;
    logic [SLOT_W-1:0] dly_slot_reg [0:ROM_LAT];
    logic [ADDR_W-1:0] rom_addr_reg;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            dly_valid_reg  <= '0;
            dly_inside_reg <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                dly_slot_reg[i] <= '0;
            end
            rom_addr_reg <= '0;
        end else begin
            dly_valid_reg[0]  <= bus.pix_en;
            dly_inside_reg[0] <= bus.pix_en && inside_next;
            dly_slot_reg[0]   <= slot_next;
            if (bus.pix_en && inside_next) begin
                rom_addr_reg <= addr_next;
            end
            for (int i = 1; i <= ROM_LAT; i++) begin
                dly_valid_reg[i]  <= dly_valid_reg[i-1];
                dly_inside_reg[i] <= dly_inside_reg[i-1];
                dly_slot_reg[i]   <= dly_slot_reg[i-1];
            end
        end
    end

    assign bus.rom_addr = rom_addr_reg;

    // Pixel 0 occupies the least significant BPP bits of the ROM word
    logic [BPP-1:0] word_pix [0:PPW-1];
    logic [BPP-1:0] idx_next;

    for (genvar gi = 0; gi < PPW; gi++) begin : g_unpack
        assign word_pix[gi] = bus.rom_data[gi*BPP +: BPP];
    end

    assign idx_next = word_pix[dly_slot_reg[ROM_LAT]];

    rgb444_t pal_rd;

    sprite_palette_ram #(.BPP(BPP)) u_palette (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .we     (bus.pal_we),
        .wr_idx (bus.pal_idx),
        .wr_rgb (bus.pal_rgb),
        .rd_idx (idx_next),
        .rd_rgb (pal_rd)
    );

    logic    ext_valid_reg;
    logic    ext_opaque_reg;
    logic    valid_reg;
    logic    hit_reg;
    rgb444_t rgb_reg;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ext_valid_reg  <= 1'b0;
            ext_opaque_reg <= 1'b0;
            valid_reg      <= 1'b0;
            hit_reg        <= 1'b0;
            rgb_reg        <= '0;
        end else begin
            ext_valid_reg  <= dly_valid_reg[ROM_LAT];
            ext_opaque_reg <= dly_inside_reg[ROM_LAT] && (idx_next != BPP'(TRANSP_IDX));
            valid_reg      <= ext_valid_reg;
            hit_reg        <= ext_opaque_reg;
            rgb_reg        <= ext_opaque_reg ? pal_rd : '0;
        end
    end

    assign bus.pix_valid = valid_reg;
    assign bus.hit       = hit_reg;
    assign bus.Red       = rgb_reg.r;
    assign bus.Green     = rgb_reg.g;
    assign bus.Blue      = rgb_reg.b;

endmodule

// File: tb/tb_sprite_palette_renderer.sv
// Randomised and directed bench for sprite_palette_renderer against a pixel-level reference model.
module tb_sprite_palette_renderer;
    localparam int SPR_W       = 20;
    localparam int SPR_H       = 20;
    localparam int BPP         = 4;
    localparam int DATA_W      = 32;
    localparam int FRAMES      = 4;
    localparam int ROM_LAT     = 1;
    localparam int ADDR_W      = 10;
    localparam int TRANSP_IDX  = 0;
    localparam int LAT         = ROM_LAT + 2;
    localparam int PPW         = DATA_W / BPP;
    localparam int FRAME_WORDS = SPR_W * SPR_H / PPW;
    localparam int ROM_DEPTH   = 1 << ADDR_W;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    sprite_palette_renderer_if #(.BPP(BPP), .DATA_W(DATA_W), .FRAMES(FRAMES), .ADDR_W(ADDR_W)) bus();

    sprite_palette_renderer #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .BPP(BPP), .DATA_W(DATA_W), .FRAMES(FRAMES),
        .ROM_LAT(ROM_LAT), .ADDR_W(ADDR_W), .TRANSP_IDX(TRANSP_IDX)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    // Sprite ROM with ROM_LAT cycles of read latency
    logic [DATA_W-1:0] rom_mem  [0:ROM_DEPTH-1];
    logic [DATA_W-1:0] rom_pipe [0:ROM_LAT-1];

    always @(posedge Clk) begin
        rom_pipe[0] <= rom_mem[bus.rom_addr];
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bus.rom_data = rom_pipe[ROM_LAT-1];

    // Reference model state
    typedef struct {
        longint     born;
        int         x;
        int         y;
        bit         valid;
        bit         hit;
        int         idx;
        logic [11:0] rgb;
    } pix_t;

    pix_t        q[$];
    longint      ecount = 0;
    int          sh_x, sh_y, sh_frame;
    bit          sh_flip, vs_prev;
    logic [11:0] pal_model [0:(1<<BPP)-1];
    int          exp_rom_addr;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        sh_x = 0; sh_y = 0; sh_frame = 0; sh_flip = 0; vs_prev = 0;
        exp_rom_addr = 0;
        for (int i = 0; i < (1 << BPP); i++) pal_model[i] = 12'(i * 12'h111);
    endtask

    task automatic model_edge();
        pix_t e;
        int x, y, c, l, a, s, fs;
        if (!Reset_n) begin
            model_reset();
            return;
        end
        x = int'(bus.DrawX);
        y = int'(bus.DrawY);
        e.born = ecount; e.x = x; e.y = y; e.valid = bus.pix_en;
        e.hit = 0; e.idx = 0; e.rgb = 12'h000;
        if (bus.pix_en && x >= sh_x && x < sh_x + SPR_W && y >= sh_y && y < sh_y + SPR_H) begin
            c = sh_flip ? (SPR_W - 1 - (x - sh_x)) : (x - sh_x);
            l = (y - sh_y) * SPR_W + c;
            a = sh_frame * FRAME_WORDS + l / PPW;
            s = l % PPW;
            e.idx = int'((rom_mem[a] >> (s * BPP)) & ((1 << BPP) - 1));
            e.hit = (e.idx != TRANSP_IDX);
            exp_rom_addr = a;
        end
        q.push_back(e);
        // Palette is consulted one edge before the output; a write on that edge is not yet seen
        foreach (q[i]) begin
            if (ecount - q[i].born == LAT - 1) q[i].rgb = q[i].hit ? pal_model[q[i].idx] : 12'h000;
        end
        if (bus.pal_we) pal_model[bus.pal_idx] = bus.pal_rgb;
        if (bus.vsync && !vs_prev) begin
            fs = int'(bus.frame_sel);
            sh_x = int'(bus.SprX); sh_y = int'(bus.SprY); sh_flip = bus.flip;
            sh_frame = (fs >= FRAMES) ? FRAMES - 1 : fs;
        end
        vs_prev = bus.vsync;
    endtask

    task automatic compare_outputs();
        pix_t e;
        bit exp_valid = 0, exp_hit = 0;
        logic [11:0] exp_rgb = 12'h000;
        if (q.size() > 0 && ecount - q[0].born == LAT) begin
            e = q.pop_front();
            exp_valid = e.valid; exp_hit = e.hit; exp_rgb = e.rgb;
            if (e.valid)
                $display("pix t=%0d x=%0d y=%0d idx=%0d hit=%0b rgb=%03h", ecount, e.x, e.y, e.idx, bus.hit, {bus.Red, bus.Green, bus.Blue});
        end
        check_val("pix_valid", bus.pix_valid, exp_valid);
        check_val("hit", bus.hit, exp_hit);
        check_val("rgb", {bus.Red, bus.Green, bus.Blue}, exp_rgb);
        check_val("rom_addr", bus.rom_addr, exp_rom_addr);
    endtask

    task automatic tick();
        @(posedge Clk);
        ecount++;
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic present(input int x, input int y);
        bus.DrawX = 10'(x); bus.DrawY = 10'(y); bus.pix_en = 1'b1;
        tick();
        bus.pix_en = 1'b0;
        repeat (LAT) tick();
    endtask

    task automatic vsync_pulse();
        bus.vsync = 1'b1; tick();
        bus.vsync = 1'b0; tick();
    endtask

    task automatic set_sprite(input int x, input int y, input bit f, input int fr);
        bus.SprX = 10'(x); bus.SprY = 10'(y); bus.flip = f; bus.frame_sel = 2'(fr);
    endtask

    task automatic pal_write(input int idx, input logic [11:0] rgb);
        bus.pal_we = 1'b1; bus.pal_idx = 4'(idx); bus.pal_rgb = rgb;
        tick();
        bus.pal_we = 1'b0;
    endtask

    task automatic check_pixel(input string tag, input bit exp_hit, input logic [11:0] exp_rgb);
        check_val({tag, "_valid"}, bus.pix_valid, 1);
        check_val({tag, "_hit"}, bus.hit, exp_hit);
        check_val({tag, "_rgb"}, {bus.Red, bus.Green, bus.Blue}, exp_rgb);
    endtask

    initial begin
        for (int i = 0; i < ROM_DEPTH; i++) rom_mem[i] = $urandom;
        bus.pix_en = 0; bus.DrawX = 0; bus.DrawY = 0; bus.vsync = 0;
        bus.pal_we = 0; bus.pal_idx = 0; bus.pal_rgb = 0;
        set_sprite(0, 0, 0, 0);
        model_reset();

        Reset_n = 0;
        repeat (3) tick();
        check_val("rst_valid", bus.pix_valid, 0);
        check_val("rst_rgb", {bus.Red, bus.Green, bus.Blue}, 0);
        check_val("rst_rom_addr", bus.rom_addr, 0);
        Reset_n = 1;
        tick();

        // Basic pixel: idx 5 in slot 3 of word 0
        pal_write(5, 12'hE12);
        rom_mem[0] = 32'h0000_5000;
        set_sprite(100, 50, 0, 0);
        vsync_pulse();
        present(103, 50);
        check_pixel("basic", 1, 12'hE12);
        check_val("basic_addr", bus.rom_addr, 0);

        // Palette write on the lookup edge returns the old colour
        bus.DrawX = 10'd103; bus.DrawY = 10'd50; bus.pix_en = 1;
        tick();
        bus.pix_en = 0;
        repeat (LAT - 2) tick();
        pal_write(5, 12'hABC);
        tick();
        check_pixel("collide_old", 1, 12'hE12);
        present(103, 50);
        check_pixel("collide_new", 1, 12'hABC);
        pal_write(5, 12'hE12);

        // Horizontal flip
        rom_mem[2] = 32'h0000_0005;
        set_sprite(100, 50, 1, 0);
        vsync_pulse();
        present(103, 50);
        check_pixel("flip", 1, 12'hE12);
        check_val("flip_addr", bus.rom_addr, 2);

        present(120, 50);
        check_pixel("right_edge", 0, 12'h000);

        // Animation frame 2
        rom_mem[102] = 32'h0005_0000;
        set_sprite(100, 50, 0, 2);
        vsync_pulse();
        present(100, 51);
        check_pixel("frame2", 1, 12'hE12);
        check_val("frame2_addr", bus.rom_addr, 102);

        // Mid-frame SprX change is held off until vsync
        rom_mem[100] = 32'h0000_5000;
        set_sprite(110, 50, 0, 2);
        present(103, 50);
        check_pixel("shadow_old", 1, 12'hE12);
        vsync_pulse();
        present(103, 50);
        check_pixel("shadow_new_out", 0, 12'h000);
        present(113, 50);
        check_pixel("shadow_new_in", 1, 12'hE12);

        // Transparent index inside the box
        present(110, 50);
        check_pixel("transp", 0, 12'h000);

        // Randomised traffic against the model
        for (int i = 0; i < 2500; i++) begin
            if (i % 250 == 0) begin
                set_sprite(($urandom_range(0, 7) == 0) ? $urandom_range(1004, 1023) : $urandom_range(0, 600),
                           $urandom_range(0, 460), 1'($urandom_range(0, 1)), $urandom_range(0, FRAMES - 1));
            end
            if (i % 250 == 3) bus.vsync = 1;
            if (i % 250 == 6) bus.vsync = 0;
            if (i % 250 == 100) bus.SprX = 10'($urandom_range(0, 1023));
            bus.pix_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.DrawX = 10'($urandom_range(0, 1023));
                bus.DrawY = 10'($urandom_range(0, 1023));
            end else begin
                bus.DrawX = 10'(sh_x - 3 + int'($urandom_range(0, SPR_W + 5)));
                bus.DrawY = 10'(sh_y - 3 + int'($urandom_range(0, SPR_H + 5)));
            end
            bus.pal_we  = ($urandom_range(0, 7) == 0);
            bus.pal_idx = 4'($urandom_range(0, 15));
            bus.pal_rgb = 12'($urandom);
            tick();
        end
        bus.pal_we = 0; bus.vsync = 0;

        // Reset in the middle of a stream
        bus.pix_en = 1; bus.DrawX = 10'(sh_x); bus.DrawY = 10'(sh_y);
        repeat (2) tick();
        Reset_n = 0;
        tick();
        check_val("midrst_valid", bus.pix_valid, 0);
        bus.pix_en = 0;
        tick();
        Reset_n = 1;
        rom_mem[0] = 32'h0000_5000;
        set_sprite(100, 50, 0, 0);
        vsync_pulse();
        present(103, 50);
        check_pixel("grey_after_rst", 1, 12'h555);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
